uart_alu_frame_ctrl: RTL and testbench

Parametrised frame controller between the UART RX/TX FIFOs and the ALU. It is the multi-byte successor to the single-byte RX/TX interface pair. It parses a header-delimited, checksummed command frame from the RX FIFO and assembles DATA_W-bit operands A and B plus an opcode. It then drives the ALU, captures the result, and streams a checksummed response into the TX FIFO, handling TX back-pressure, inter-byte timeout and checksum errors.

---
 rtl/uart_alu_frame_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_alu_frame_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller between the UART RX/TX FIFOs and the ALU.
// Parses HEADER | A[NB] | B[NB] | OP | CHK from the RX FIFO, drives the ALU,
// then streams NB result bytes plus their XOR (or ERR_CODE) into the TX FIFO.
module uart_alu_frame_ctrl #(
    parameter int         DATA_W      = 16,
    parameter int         OP_W        = 6,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter logic [7:0] ERR_CODE    = 8'hEE,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              wr_uart,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_res,
    output logic [2:0]        state,
    output logic              busy,
    output logic              frame_err,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(NB + 2);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(NB);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RX_A   = 3'd1,
        S_RX_B   = 3'd2,
        S_RX_OP  = 3'd3,
        S_RX_CHK = 3'd4,
        S_EXEC   = 3'd5,
        S_TX_RES = 3'd6,
        S_TX_ERR = 3'd7
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] shift_sr;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] res_sr;
    logic [7:0]        rx_chk;
    logic [7:0]        res_chk;
    logic [TO_W-1:0]   idle_cnt;
    logic              exec_wait;
    logic              in_rx;
    logic              timeout;
    logic              chk_bad;

    // XOR of all bytes of a result word, used as the response checksum.
    function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NB; i++) begin
            acc = acc ^ v[i*8 +: 8];
        end
        return acc;
    endfunction

    assign in_rx   = cur_state inside {S_RX_A, S_RX_B, S_RX_OP, S_RX_CHK};
    // Reset gates the pop so no byte is consumed while the controller is held.
    assign rd_uart = (in_rx || cur_state == S_IDLE) && !rx_empty && !rst;
    assign wr_uart = (cur_state inside {S_TX_RES, S_TX_ERR}) && !tx_full;
    assign timeout = in_rx && !rd_uart && (idle_cnt == TO_LAST);
    assign chk_bad = (cur_state == S_RX_CHK) && rd_uart && (rx_data != rx_chk);
    assign shifted = (shift_sr << 8) | DATA_W'(rx_data);
    assign state   = cur_state;
    assign busy    = (cur_state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block evaluation order.
        if (rst) cur_state <= S_IDLE;
        else     cur_state <= nxt_state;
    end

    // Next-state decode and TX byte selection.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        nxt_state = cur_state;
        tx_data   = 8'h00;
        case (cur_state)
            S_IDLE: begin
                if (rd_uart && rx_data == HEADER) nxt_state = S_RX_A;
            end
            S_RX_A: begin
                if (timeout)                             nxt_state = S_IDLE;
                else if (rd_uart && byte_idx == LAST_IDX) nxt_state = S_RX_B;
            end
            S_RX_B: begin
                if (timeout)                             nxt_state = S_IDLE;
                else if (rd_uart && byte_idx == LAST_IDX) nxt_state = S_RX_OP;
            end
            S_RX_OP: begin
                if (timeout)      nxt_state = S_IDLE;
                else if (rd_uart) nxt_state = S_RX_CHK;
            end
            S_RX_CHK: begin
                if (timeout)      nxt_state = S_IDLE;
                else if (rd_uart) nxt_state = chk_bad ? S_TX_ERR : S_EXEC;
            end
            S_EXEC: begin
                if (exec_wait) nxt_state = S_TX_RES;
            end
            S_TX_RES: begin
                tx_data = (byte_idx == CHK_IDX) ? res_chk : res_sr[DATA_W-1 -: 8];
                if (wr_uart && byte_idx == CHK_IDX) nxt_state = S_IDLE;
            end
            S_TX_ERR: begin
                tx_data = ERR_CODE;
                if (wr_uart) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Inter-byte idle counter; only runs while inside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             idle_cnt <= '0;
        else if (!in_rx || rd_uart || timeout) idle_cnt <= '0;
        else                                 idle_cnt <= idle_cnt + TO_W'(1);
    end

    // Byte position within the current operand field or response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= '0;
        end else begin
            case (cur_state)
                S_IDLE, S_EXEC: byte_idx <= '0;
                S_RX_A, S_RX_B: begin
                    if (rd_uart) byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);
                end
                S_TX_RES: begin
                    if (wr_uart) byte_idx <= byte_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Operand assembly and running checksum; ALU inputs change only on a field's last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_sr <= '0;
            rx_chk   <= 8'h00;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
        end else if (rd_uart) begin
            case (cur_state)
                S_IDLE: begin
                    if (rx_data == HEADER) rx_chk <= 8'h00;
                end
                S_RX_A: begin
                    shift_sr <= shifted;
                    rx_chk   <= rx_chk ^ rx_data;
                    if (byte_idx == LAST_IDX) alu_a <= shifted;
                end
                S_RX_B: begin
                    shift_sr <= shifted;
                    rx_chk   <= rx_chk ^ rx_data;
                    if (byte_idx == LAST_IDX) alu_b <= shifted;
                end
                S_RX_OP: begin
                    rx_chk <= rx_chk ^ rx_data;
                    alu_op <= rx_data[OP_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Result capture one cycle into EXEC, then MSB-first shift-out during TX_RES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_wait <= 1'b0;
            res_sr    <= '0;
            res_chk   <= 8'h00;
        end else begin
            case (cur_state)
                S_EXEC: begin
                    if (!exec_wait) begin
                        exec_wait <= 1'b1;
                    end else begin
                        exec_wait <= 1'b0;
                        res_sr    <= alu_res;
                        res_chk   <= xor_bytes(alu_res);
                    end
                end
                S_TX_RES: begin
                    if (wr_uart && byte_idx != CHK_IDX) res_sr <= res_sr << 8;
                end
                default: exec_wait <= 1'b0;
            endcase
        end
    end

    // Error pulse and good/error frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            err_cnt   <= 8'h00;
            frame_cnt <= 8'h00;
        end else begin
            frame_err <= 1'b0;
            if (timeout || chk_bad) begin
                frame_err <= 1'b1;
                err_cnt   <= err_cnt + 8'd1;
            end
            if (cur_state == S_TX_RES && wr_uart && byte_idx == CHK_IDX) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Self-checking bench for uart_alu_frame_ctrl: FIFO-style RX/TX environment,
// a frame-level reference model, directed cases and a randomized stream.
module tb_uart_alu_frame_ctrl;

    localparam int         DATA_W  = 16;
    localparam int         OP_W    = 6;
    localparam int         NB      = DATA_W / 8;
    localparam int         TIMEOUT = 50;
    localparam logic [7:0] HDR     = 8'hA5;
    localparam logic [7:0] ERRC    = 8'hEE;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_empty;
    logic [7:0]        rx_data;
    logic              rd_uart;
    logic              tx_full;
    logic [7:0]        tx_data;
    logic              wr_uart;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_res;
    logic [2:0]        state;
    logic              busy;
    logic              frame_err;
    logic [7:0]        frame_cnt;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    uart_alu_frame_ctrl #(
        .DATA_W(DATA_W), .OP_W(OP_W), .HEADER(HDR), .ERR_CODE(ERRC), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .tx_data(tx_data), .wr_uart(wr_uart), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_res(alu_res), .state(state), .busy(busy), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    // Small combinational ALU standing in for the real one.
    function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a, b, input logic [OP_W-1:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_a, alu_b, alu_op);

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]        data;
        bit                has_ops;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_rd_cyc = 0;
    int         first_wr_cyc = -1;
    int         err_pulses = 0;
    int         exp_frames = 0;
    int         exp_errs = 0;
    bit         gaps_en = 1'b0;
    bit         bp_en = 1'b0;
    bit         force_full = 1'b0;
    bit         pop_now = 1'b0;
    bit         prev_ferr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got wait budget expired, expected event", name);
    endtask

    // Build one command frame; chk_flip != 0 corrupts the checksum.
    function automatic bq_t make_frame(input logic [DATA_W-1:0] a, b, input logic [7:0] op,
                                       input logic [7:0] chk_flip);
        bq_t        f;
        logic [7:0] x;
        x = 8'h00;
        f.push_back(HDR);
        for (int k = 0; k < NB; k++) begin
            f.push_back(a[(NB-1-k)*8 +: 8]);
            x = x ^ a[(NB-1-k)*8 +: 8];
        end
        for (int k = 0; k < NB; k++) begin
            f.push_back(b[(NB-1-k)*8 +: 8]);
            x = x ^ b[(NB-1-k)*8 +: 8];
        end
        f.push_back(op);
        x = x ^ op;
        f.push_back(x ^ chk_flip);
        return f;
    endfunction

    // Reference model: scan a byte stream, predict the response of every frame, feed the RX FIFO.
    task automatic model_stream(input bq_t s);
        int                i;
        logic [DATA_W-1:0] a, b, r;
        logic [7:0]        x;
        logic [OP_W-1:0]   op;
        exp_t              e;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != HDR) begin
                i++;
            end else begin
                a = '0;
                b = '0;
                x = 8'h00;
                for (int k = 0; k < NB; k++) begin
                    a = (a << 8) | DATA_W'(s[i+1+k]);
                    b = (b << 8) | DATA_W'(s[i+1+NB+k]);
                    x = x ^ s[i+1+k] ^ s[i+1+NB+k];
                end
                x  = x ^ s[i+1+2*NB];
                op = s[i+1+2*NB][OP_W-1:0];
                if (x == s[i+2+2*NB]) begin
                    r = alu_fn(a, b, op);
                    x = 8'h00;
                    for (int k = NB - 1; k >= 0; k--) begin
                        e = '{data: r[k*8 +: 8], has_ops: 1'b1, a: a, b: b, op: op};
                        exp_q.push_back(e);
                        x = x ^ r[k*8 +: 8];
                    end
                    e = '{data: x, has_ops: 1'b1, a: a, b: b, op: op};
                    exp_q.push_back(e);
                    exp_frames++;
                end else begin
                    e = '{data: ERRC, has_ops: 1'b0, a: '0, b: '0, op: '0};
                    exp_q.push_back(e);
                    exp_errs++;
                end
                i += 3 + 2 * NB;
            end
        end
        foreach (s[j]) rx_q.push_back(s[j]);
    endtask

    task automatic raw_push(input bq_t s);
        foreach (s[j]) rx_q.push_back(s[j]);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(rx_q.size() == 0 && exp_q.size() == 0 && busy == 1'b0) && n < budget);
        if (n >= budget) fail_bound(name);
        check({name, "_frame_cnt"}, frame_cnt, exp_frames[7:0]);
        check({name, "_err_cnt"}, err_cnt, exp_errs[7:0]);
        check({name, "_err_pulses"}, err_pulses, exp_errs);
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] b0, b1, b2);
        logic [7:0] want[3];
        want = '{b0, b1, b2};
        check({name, "_count"}, tx_log.size(), n);
        for (int k = 0; k < n && k < tx_log.size(); k++) check({name, "_byte"}, tx_log[k], want[k]);
    endtask

    // RX/TX FIFO environment: pops accepted bytes, optional gaps and back-pressure.
    initial begin
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        tx_full  = 1'b0;
        forever begin
            @(negedge clk);
            pop_now = rd_uart;
            @(posedge clk);
            #1;
            if (pop_now && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_empty = (rx_q.size() == 0) || (gaps_en && $urandom_range(0, 3) == 0);
            rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            tx_full  = force_full || (bp_en && $urandom_range(0, 2) == 0);
        end
    end

    // Compare process: every pushed TX byte against the model, plus handshake rules.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_uart) begin
                last_rd_cyc = cyc;
                check("rd_when_empty", rx_empty, 1'b0);
            end
            if (wr_uart) begin
                check("wr_when_full", tx_full, 1'b0);
                tx_log.push_back(tx_data);
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail_bound("unexpected_tx_byte");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_byte", tx_data, mon_e.data);
                    if (mon_e.has_ops) begin
                        check("alu_a", alu_a, mon_e.a);
                        check("alu_b", alu_b, mon_e.b);
                        check("alu_op", alu_op, mon_e.op);
                    end
                end
            end
            if (frame_err) begin
                err_pulses++;
                check("frame_err_one_cycle", prev_ferr, 1'b0);
            end
            prev_ferr = frame_err;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t        s;
        bq_t        f;
        int         n;
        logic [7:0] g;
        logic [7:0] op8;
        logic [7:0] flip;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", state, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_uart", rd_uart, 1'b0);
        check("rst_wr_uart", wr_uart, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_cnt", frame_cnt, 8'h00);
        check("rst_err_cnt", err_cnt, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;

        // Basic good frame: 5 + 3.
        tx_log.delete();
        first_wr_cyc = -1;
        model_stream(make_frame(16'h0005, 16'h0003, 8'h20, 8'h00));
        wait_done("good", 200);
        check_log("good_resp", 3, 8'h00, 8'h08, 8'h08);
        check("good_alu_a", alu_a, 16'h0005);
        check("good_alu_b", alu_b, 16'h0003);
        check("good_alu_op", alu_op, 6'h20);
        check("good_frame_cnt_lit", frame_cnt, 8'd1);
        check("good_no_err", err_pulses, 0);
        check("good_latency", first_wr_cyc - last_rd_cyc, 3);

        // Same frame with checksum 27 instead of 26.
        tx_log.delete();
        first_wr_cyc = -1;
        model_stream(make_frame(16'h0005, 16'h0003, 8'h20, 8'h01));
        wait_done("badchk", 200);
        check_log("badchk_resp", 1, ERRC, 8'h00, 8'h00);
        check("badchk_err_cnt_lit", err_cnt, 8'd1);
        check("badchk_latency", first_wr_cyc - last_rd_cyc, 1);

        // Leading garbage is popped and discarded.
        tx_log.delete();
        s.delete();
        s.push_back(8'h11);
        s.push_back(8'h22);
        f = make_frame(16'h0005, 16'h0003, 8'h20, 8'h00);
        foreach (f[j]) s.push_back(f[j]);
        model_stream(s);
        wait_done("garbage", 200);
        check_log("garbage_resp", 3, 8'h00, 8'h08, 8'h08);

        // Inter-byte timeout after A5 00.
        tx_log.delete();
        s.delete();
        s.push_back(HDR);
        s.push_back(8'h00);
        raw_push(s);
        n = 0;
        while (rx_q.size() != 0 && n < 50) begin @(negedge clk); #1; n++; end
        if (rx_q.size() != 0) fail_bound("timeout_drain");
        n = 0;
        while (busy && n < 200) begin @(negedge clk); #1; n++; end
        if (busy) fail_bound("timeout_idle");
        check("timeout_cycles", cyc - last_rd_cyc, TIMEOUT + 1);
        check("timeout_state", state, 3'd0);
        check("timeout_no_tx", tx_log.size(), 0);
        exp_errs++;
        wait_done("timeout", 50);
        model_stream(make_frame(16'h0005, 16'h0003, 8'h20, 8'h00));
        wait_done("after_timeout", 200);
        check_log("after_timeout_resp", 3, 8'h00, 8'h08, 8'h08);

        // TX back-pressure after the first response byte.
        tx_log.delete();
        model_stream(make_frame(16'h0005, 16'h0003, 8'h20, 8'h00));
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!wr_uart && n < 100);
        check("bp_first_byte", wr_uart, 1'b1);
        force_full = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("bp_stalled", tx_log.size(), 1);
        force_full = 1'b0;
        wait_done("bp", 200);
        check_log("bp_resp", 3, 8'h00, 8'h08, 8'h08);

        // Reset while receiving operand B.
        s = make_frame(16'h0005, 16'h0003, 8'h20, 8'h00);
        raw_push(s);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (state != 3'd2 && n < 100);
        check("rst_mid_reached_rx_b", state, 3'd2);
        rst = 1'b1;
        #1;
        rx_q.delete();
        exp_q.delete();
        check("rst_mid_state", state, 3'd0);
        check("rst_mid_alu_a", alu_a, 16'h0000);
        check("rst_mid_alu_b", alu_b, 16'h0000);
        check("rst_mid_alu_op", alu_op, 6'h00);
        check("rst_mid_rd_uart", rd_uart, 1'b0);
        check("rst_mid_wr_uart", wr_uart, 1'b0);
        check("rst_mid_tx_data", tx_data, 8'h00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_frame_err", frame_err, 1'b0);
        check("rst_mid_frame_cnt", frame_cnt, 8'h00);
        check("rst_mid_err_cnt", err_cnt, 8'h00);
        exp_frames = 0;
        exp_errs   = 0;
        err_pulses = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_log.delete();
        model_stream(make_frame(16'hFFFF, 16'h0001, 8'h20, 8'h00));
        wait_done("wrap_add", 200);
        check_log("wrap_add_resp", 3, 8'h00, 8'h00, 8'h00);
        check("wrap_add_frame_cnt_lit", frame_cnt, 8'd1);

        // Randomized stream with RX gaps and TX back-pressure.
        gaps_en = 1'b1;
        bp_en   = 1'b1;
        for (int batch = 0; batch < 4; batch++) begin
            for (int fr = 0; fr < 10; fr++) begin
                s.delete();
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    do g = 8'($urandom); while (g == HDR);
                    s.push_back(g);
                end
                case ($urandom_range(0, 5))
                    0: op8 = 8'h20;
                    1: op8 = 8'h22;
                    2: op8 = 8'h24;
                    3: op8 = 8'h25;
                    4: op8 = 8'h26;
                    default: op8 = 8'($urandom);
                endcase
                op8[7:6] = 2'($urandom);
                flip = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                f = make_frame(16'($urandom), 16'($urandom), op8, flip);
                foreach (f[j]) s.push_back(f[j]);
                model_stream(s);
            end
            wait_done("random", 3000);
        end
        gaps_en = 1'b0;
        bp_en   = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
